// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences FETCH/DECODE/EXEC/MEM/WB
// states and drives datapath selects, strobes and a retired-instruction counter.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   opcode           instruction[6:0] from the registered IR
//   zero             ALU zero flag (branch decision)
//   mem_ready        memory completion for the current request
//   ALU_op           00 add, 01 sub, 10 funct-decoded
//   alu_src_a/b      ALU operand selects
//   iord .. mem_to_reg  datapath strobes/selects
//   illegal          unsupported opcode seen in DECODE
//   state            current state encoding (debug)
//   instr_count      retired instruction count (wraps)
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALU_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;
    state_t state_d;
    logic   retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            instr_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = FETCH;
        ALU_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:      state_d = EXEC_R;
                    OP_I:      state_d = EXEC_I;
                    OP_LOAD,
                    OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH: state_d = BRANCH;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                ALU_op    = 2'b10;
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                ALU_op    = 2'b10;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
                state_d   = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                ALU_op    = 2'b01;
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset overrides everything: strobes off, selects at FETCH values.
        if (!rst_n) begin
            state_d    = FETCH;
            ALU_op     = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b01;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
            retire     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control.
// Ctrl vector: {ALU_op,a,b,iord,mrd,mwr,irw,pcw,pcs,rw,m2r,ill}
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  ALU_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ALU_op      (ALU_op),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    //                          op  a   b   io r w ir pw ps rw mr il
    localparam logic [14:0] C_RST = 15'b00_00_01_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] C_FNR = 15'b00_00_01_0_1_0_0_0_0_0_0_0;
    localparam logic [14:0] C_FRD = 15'b00_00_01_0_1_0_1_1_0_0_0_0;
    localparam logic [14:0] C_DEC = 15'b00_00_10_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] C_ILL = 15'b00_00_10_0_0_0_0_0_0_0_0_1;
    localparam logic [14:0] C_EXR = 15'b10_01_00_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] C_EXI = 15'b10_01_10_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] C_AWB = 15'b00_00_00_0_0_0_0_0_0_1_0_0;
    localparam logic [14:0] C_MAD = 15'b00_01_10_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] C_MRD = 15'b00_00_00_1_1_0_0_0_0_0_0_0;
    localparam logic [14:0] C_MWB = 15'b00_00_00_0_0_0_0_0_0_1_1_0;
    localparam logic [14:0] C_MWR = 15'b00_00_00_1_0_1_0_0_0_0_0_0;
    localparam logic [14:0] C_BR1 = 15'b01_01_00_0_0_0_0_1_1_0_0_0;
    localparam logic [14:0] C_BR0 = 15'b01_01_00_0_0_0_0_0_1_0_0_0;

    typedef struct {
        logic        rst_n;
        logic [6:0]  opcode;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] ctrl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[38];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(logic r, logic [6:0] o, logic z,
                                logic m, logic [3:0] s,
                                logic [14:0] c, logic [31:0] n);
        vec_t v;
        v.rst_n = r; v.opcode = o; v.zero = z; v.rdy = m;
        v.st = s; v.ctrl = c; v.cnt = n;
        return v;
    endfunction

    function automatic logic [14:0] ctrl_now();
        return {ALU_op, alu_src_a, alu_src_b, iord, mem_read,
                mem_write, ir_write, pc_write, pc_src, reg_write,
                mem_to_reg, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = mk(0, R,  0, 1, 4'd0, C_RST, 32'd0);
        vecs[1]  = mk(1, R,  0, 1, 4'd0, C_FRD, 32'd0);
        vecs[2]  = mk(1, R,  0, 1, 4'd1, C_DEC, 32'd0);
        vecs[3]  = mk(1, R,  0, 1, 4'd2, C_EXR, 32'd0);
        vecs[4]  = mk(1, R,  0, 1, 4'd4, C_AWB, 32'd0);
        vecs[5]  = mk(1, I,  0, 0, 4'd0, C_FNR, 32'd1);
        vecs[6]  = mk(1, I,  0, 1, 4'd0, C_FRD, 32'd1);
        vecs[7]  = mk(1, I,  0, 1, 4'd1, C_DEC, 32'd1);
        vecs[8]  = mk(1, I,  0, 1, 4'd3, C_EXI, 32'd1);
        vecs[9]  = mk(1, I,  0, 1, 4'd4, C_AWB, 32'd1);
        vecs[10] = mk(1, LD, 0, 1, 4'd0, C_FRD, 32'd2);
        vecs[11] = mk(1, LD, 0, 1, 4'd1, C_DEC, 32'd2);
        vecs[12] = mk(1, LD, 0, 1, 4'd5, C_MAD, 32'd2);
        vecs[13] = mk(1, LD, 0, 0, 4'd6, C_MRD, 32'd2);
        vecs[14] = mk(1, LD, 0, 0, 4'd6, C_MRD, 32'd2);
        vecs[15] = mk(1, LD, 0, 0, 4'd6, C_MRD, 32'd2);
        vecs[16] = mk(1, LD, 0, 1, 4'd6, C_MRD, 32'd2);
        vecs[17] = mk(1, LD, 0, 1, 4'd7, C_MWB, 32'd2);
        vecs[18] = mk(1, BR, 1, 1, 4'd0, C_FRD, 32'd3);
        vecs[19] = mk(1, BR, 1, 1, 4'd1, C_DEC, 32'd3);
        vecs[20] = mk(1, BR, 1, 1, 4'd9, C_BR1, 32'd3);
        vecs[21] = mk(1, BR, 0, 1, 4'd0, C_FRD, 32'd4);
        vecs[22] = mk(1, BR, 0, 1, 4'd1, C_DEC, 32'd4);
        vecs[23] = mk(1, BR, 0, 1, 4'd9, C_BR0, 32'd4);
        vecs[24] = mk(1, BAD, 0, 1, 4'd0, C_FRD, 32'd5);
        vecs[25] = mk(1, BAD, 0, 1, 4'd1, C_ILL, 32'd5);
        vecs[26] = mk(1, ST, 0, 1, 4'd0, C_FRD, 32'd5);
        vecs[27] = mk(1, ST, 0, 1, 4'd1, C_DEC, 32'd5);
        vecs[28] = mk(1, ST, 0, 1, 4'd5, C_MAD, 32'd5);
        vecs[29] = mk(1, ST, 0, 0, 4'd8, C_MWR, 32'd5);
        vecs[30] = mk(1, ST, 0, 1, 4'd8, C_MWR, 32'd5);
        vecs[31] = mk(1, R,  0, 1, 4'd0, C_FRD, 32'd6);
        vecs[32] = mk(1, ST, 0, 1, 4'd1, C_DEC, 32'd6);
        vecs[33] = mk(1, ST, 0, 1, 4'd5, C_MAD, 32'd6);
        vecs[34] = mk(1, ST, 0, 0, 4'd8, C_MWR, 32'd6);
        vecs[35] = mk(0, ST, 0, 1, 4'd8, C_RST, 32'd6);
        vecs[36] = mk(1, ST, 0, 0, 4'd0, C_FNR, 32'd0);
        vecs[37] = mk(1, ST, 0, 1, 4'd0, C_FRD, 32'd0);

        rst_n     = 1'b0;
        opcode    = R;
        zero      = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 38; i++) begin
            rst_n     = vecs[i].rst_n;
            opcode    = vecs[i].opcode;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d state", i), {28'd0, state},
                {28'd0, vecs[i].st});
            chk($sformatf("row%0d ctrl", i), {17'd0, ctrl_now()},
                {17'd0, vecs[i].ctrl});
            chk($sformatf("row%0d count", i), instr_count, vecs[i].cnt);
            tick();
        end

        // Now in DECODE with a store opcode; preload the counter to
        // its maximum and retire one store to observe the wrap.
        dut.instr_count = 32'hFFFF_FFFF;
        opcode    = ST;
        mem_ready = 1'b1;
        #1;
        chk("wrap decode state", {28'd0, state}, 32'd1);
        tick();
        chk("wrap memaddr state", {28'd0, state}, 32'd5);
        tick();
        chk("wrap memwr state", {28'd0, state}, 32'd8);
        chk("wrap pre count", instr_count, 32'hFFFF_FFFF);
        tick();
        chk("wrap fetch state", {28'd0, state}, 32'd0);
        chk("wrap count", instr_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
